// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_LINES  = 32;

  function automatic int calcOffW(input int lineW);
    return $clog2(lineW / 8);
  endfunction

  function automatic int calcIdxW(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calcTagW(input int addrW, input int lineW, input int lines);
    return addrW - calcIdxW(lines) - calcOffW(lineW);
  endfunction

  function automatic int calcWordsPerLine(input int lineW, input int dataW);
    return lineW / dataW;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write.
// Only valid and dirty bits are reset; tag and data contents are left as-is.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int LINES  = DEF_LINES,
  parameter int TAG_W  = 22
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic [$clog2(LINES)-1:0]                       i_rdIdx,
  output logic [TAG_W-1:0]                               o_tag,
  output logic                                           o_valid,
  output logic                                           o_dirty,
  output logic [LINE_W-1:0]                              o_line,
  input  logic                                           i_stEn,
  input  logic [$clog2(calcWordsPerLine(LINE_W,DATA_W))-1:0] i_stWord,
  input  logic [DATA_W-1:0]                              i_stData,
  input  logic                                           i_fillEn,
  input  logic [$clog2(LINES)-1:0]                       i_fillIdx,
  input  logic [TAG_W-1:0]                               i_fillTag,
  input  logic [LINE_W-1:0]                              i_fillLine
);

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  assign o_tag   = r_tag[i_rdIdx];
  assign o_valid = r_valid[i_rdIdx];
  assign o_dirty = r_dirty[i_rdIdx];
  assign o_line  = r_data[i_rdIdx];

  // A fill installs a clean valid line; a store hit marks its line dirty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fillEn) begin
      r_valid[i_fillIdx] <= 1'b1;
      r_dirty[i_fillIdx] <= 1'b0;
    end else if (i_stEn) begin
      r_dirty[i_rdIdx] <= 1'b1;
    end
  end

  // Line/tag replacement on fill, single-word merge on store.
  always_ff @(posedge i_clk) begin
    if (i_fillEn) begin
      r_data[i_fillIdx] <= i_fillLine;
      r_tag[i_fillIdx]  <= i_fillTag;
    end else if (i_stEn) begin
      r_data[i_rdIdx][i_stWord*DATA_W +: DATA_W] <= i_stData;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int LINES  = DEF_LINES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W  = calcOffW(LINE_W);
  localparam int IDX_W  = calcIdxW(LINES);
  localparam int TAG_W  = calcTagW(ADDR_W, LINE_W, LINES);
  localparam int BSEL_W = $clog2(DATA_W / 8);
  localparam int WSEL_W = $clog2(calcWordsPerLine(LINE_W, DATA_W));

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-OFF_W-1:0] r_missLine;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [LINE_W-1:0]   r_memWdata;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [WSEL_W-1:0]   w_word;
  logic [TAG_W-1:0]    w_victimTag;
  logic                w_valid;
  logic                w_dirty;
  logic [LINE_W-1:0]   w_line;
  logic                w_hit;
  logic                w_access;
  logic                w_storeEn;
  logic                w_fillEn;
  logic                w_unused;

  assign w_tag    = addr_i[ADDR_W-1 -: TAG_W];
  assign w_idx    = addr_i[OFF_W +: IDX_W];
  assign w_word   = addr_i[BSEL_W +: WSEL_W];
  assign w_unused = ^addr_i[BSEL_W-1:0];
  assign w_hit    = w_valid & (w_victimTag == w_tag);

  dcache_sram #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .LINES  (LINES),
    .TAG_W  (TAG_W)
  ) u_sram (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_rdIdx    (w_idx),
    .o_tag      (w_victimTag),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty),
    .o_line     (w_line),
    .i_stEn     (w_storeEn),
    .i_stWord   (w_word),
    .i_stData   (wdata_i),
    .i_fillEn   (w_fillEn),
    .i_fillIdx  (r_missLine[IDX_W-1:0]),
    .i_fillTag  (r_missLine[ADDR_W-OFF_W-1 -: TAG_W]),
    .i_fillLine (mem_rdata_i)
  );

  // State register; reset aborts any memory transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next state: a dirty valid victim is written back before the fill; once
  // the CPU has withdrawn its request, no fill follows a write-back.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (req_i && !w_hit) w_nextState = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) w_nextState = req_i ? ALLOCATE : IDLE;
      ALLOCATE:  if (mem_ack_i) w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Outputs and array write enables derived from state and lookup result.
  always_comb begin
    w_access  = req_i && (r_state == IDLE) && w_hit;
    w_storeEn = w_access && we_i;
    w_fillEn  = (r_state == ALLOCATE) && mem_ack_i;
    stall_o   = req_i && ((r_state != IDLE) || !w_hit);
    mem_req_o = (r_state != IDLE);
    rdata_o   = '0;
    if (w_access && !we_i) rdata_o = w_line[w_word*DATA_W +: DATA_W];
  end

  // Memory request fields are captured on state entry and held until the ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_missLine <= '0;
    end else if (r_state == IDLE && w_nextState == WRITEBACK) begin
      r_memWe    <= 1'b1;
      r_memAddr  <= {w_victimTag, w_idx, {OFF_W{1'b0}}};
      r_memWdata <= w_line;
      r_missLine <= addr_i[ADDR_W-1:OFF_W];
    end else if (r_state == IDLE && w_nextState == ALLOCATE) begin
      r_memWe    <= 1'b0;
      r_memAddr  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      r_memWdata <= '0;
      r_missLine <= addr_i[ADDR_W-1:OFF_W];
    end else if (r_state == WRITEBACK && w_nextState == ALLOCATE) begin
      r_memWe    <= 1'b0;
      r_memAddr  <= {r_missLine, {OFF_W{1'b0}}};
      r_memWdata <= '0;
    end
  end

  assign mem_we_o    = r_memWe;
  assign mem_addr_o  = r_memAddr;
  assign mem_wdata_o = r_memWdata;

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;
  logic        r_retry;

  // Count fresh misses and first-time hits; the post-refill retry is neither.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
      r_retry   <= 1'b0;
    end else begin
      if (r_state == IDLE && req_i && !w_hit) begin
        r_missCnt <= r_missCnt + 32'd1;
        r_retry   <= 1'b1;
      end else if (w_access) begin
        if (!r_retry) r_hitCnt <= r_hitCnt + 32'd1;
        r_retry <= 1'b0;
      end else if (r_state != IDLE && !req_i) begin
        r_retry <= 1'b0;
      end
    end
  end

  assign hit_cnt_o  = r_hitCnt;
  assign miss_cnt_o = r_missCnt;
`endif

endmodule
